// File: rtl/jt51_logsin_pipe.sv
// Pipelined quarter-wave log-sine lookup: phase fold, table read, output mute/sign.
// Three cen-qualified stages carry valid and a channel tag alongside the data.
module jt51_logsin_pipe #(
  parameter int unsigned PHW  = 10,
  parameter int unsigned OUTW = 12,
  parameter int unsigned FRAC = 8,
  parameter int unsigned CHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [PHW-1:0]  ph_in,
  input  logic [1:0]      wave,
  input  logic            valid_in,
  input  logic [CHW-1:0]  tag_in,
  output logic [OUTW-1:0] atten,
  output logic            sign,
  output logic            valid_out,
  output logic [CHW-1:0]  tag_out
);

  localparam int unsigned LOWW    = PHW - 2;
  localparam int unsigned DEPTH   = 2 ** LOWW;
  localparam int unsigned ATT_MAX = (2 ** OUTW) - 1;
  localparam real         PI      = 3.14159265358979323846;

  // Table entry sampled at the centre of each quarter-wave step, rounded and clipped
  function automatic int unsigned lut_val(input int unsigned i);
    real ang;
    real v;
    ang = (2.0 * real'(i) + 1.0) * PI / (2.0 ** PHW);
    v   = -($ln($sin(ang)) / $ln(2.0)) * (2.0 ** FRAC) + 0.5;
    if (v >= real'(ATT_MAX)) return ATT_MAX;
    return $unsigned($rtoi(v));
  endfunction

  logic [OUTW-1:0] lut [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_lut
    assign lut[g] = OUTW'(lut_val(g));
  end

  logic            msb, q;
  logic [LOWW-1:0] low;

  logic [LOWW-1:0] s1_idx_d, s1_idx_q;
  logic            s1_mute_d, s1_mute_q;
  logic            s1_sgn_d, s1_sgn_q;
  logic            s1_vld_q;
  logic [CHW-1:0]  s1_tag_q;

  logic [OUTW-1:0] s2_rom_q;
  logic            s2_mute_q, s2_sgn_q, s2_vld_q;
  logic [CHW-1:0]  s2_tag_q;

  logic [OUTW-1:0] atten_d, atten_q;
  logic            sign_d, sign_q, vld_q;
  logic [CHW-1:0]  tag_q;

  assign msb = ph_in[PHW-1];
  assign q   = ph_in[PHW-2];
  assign low = ph_in[PHW-3:0];

  // Fold the full-cycle phase onto the quarter-wave table and decode the mode
  always_comb begin
    s1_idx_d  = low;
    s1_mute_d = 1'b0;
    s1_sgn_d  = 1'b0;
    if (q && wave != 2'd3) s1_idx_d = ~low;
    case (wave)
      2'd0:    s1_sgn_d  = msb;
      2'd1:    s1_mute_d = msb;
      2'd3:    s1_mute_d = q;
      default: ;
    endcase
  end

  always_comb begin
    atten_d = s2_mute_q ? {OUTW{1'b1}} : s2_rom_q;
    sign_d  = s2_mute_q ? 1'b0 : s2_sgn_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_idx_q  <= '0;
      s1_mute_q <= 1'b0;
      s1_sgn_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_tag_q  <= '0;
      s2_rom_q  <= '0;
      s2_mute_q <= 1'b0;
      s2_sgn_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_tag_q  <= '0;
      atten_q   <= '0;
      sign_q    <= 1'b0;
      vld_q     <= 1'b0;
      tag_q     <= '0;
    end else if (cen) begin
      s1_idx_q  <= s1_idx_d;
      s1_mute_q <= s1_mute_d;
      s1_sgn_q  <= s1_sgn_d;
      s1_vld_q  <= valid_in;
      s1_tag_q  <= tag_in;
      s2_rom_q  <= lut[s1_idx_q];
      s2_mute_q <= s1_mute_q;
      s2_sgn_q  <= s1_sgn_q;
      s2_vld_q  <= s1_vld_q;
      s2_tag_q  <= s1_tag_q;
      atten_q   <= atten_d;
      sign_q    <= sign_d;
      vld_q     <= s2_vld_q;
      tag_q     <= s2_tag_q;
    end
  end

  assign atten     = atten_q;
  assign sign      = sign_q;
  assign valid_out = vld_q;
  assign tag_out   = tag_q;

endmodule
